pattern_det_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial pattern detector (data/trig in, led[4:0] out) among NREQ requesters. Each requester submits a frame of up to MAX_LEN bits. The block clears the detector, then serialises the frame as trig-qualified bits with fixed spacing. It returns the detector's LED result to the granted requester with a one-cycle done pulse. It sits between the host-side request logic and the detector instance.

---
 rtl/pattern_det_arb_pkg.sv | 27 ++
 rtl/pattern_det_arbiter_rr.sv | 25 ++
 rtl/pattern_det_arbiter.sv | 177 +++++++++++++++++
 tb/tb_pattern_det_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_arb_pkg.sv
// Shared types and default timing for the pattern detector arbiter.
// State encoding, LED width and a small constant helper live here.
package pattern_det_arb_pkg;

  localparam int LED_W       = 5;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_TRIG_HI = 1;
  localparam int DEF_GAP     = 4;
  localparam int DEF_SETTLE  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pattern_det_arbiter_rr.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// wrapping to 0. The pointer register lives in the parent.
module rr_arbiter
  import pattern_det_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  assign mask  = ~((N'(1) << ptr) - N'(1));
  assign hi    = req & mask;
  assign pick  = (|hi) ? hi : req;
  assign win   = pick & (~pick + N'(1));
  assign valid = |req;

endmodule

// File: rtl/pattern_det_arbiter.sv
// Round-robin sequencer sharing one serial pattern detector.
// Define PATTERN_DET_ARB_STICKY_EN to OR det_led over the whole frame.
module pattern_det_arbiter
  import pattern_det_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int TRIG_HI = DEF_TRIG_HI,
  parameter int GAP     = DEF_GAP,
  parameter int SETTLE  = DEF_SETTLE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*MAX_LEN-1:0] req_data,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [LED_W-1:0]        rsp_led,
  output logic                    busy,
  output logic                    det_data,
  output logic                    det_trig,
  output logic                    det_clr,
  input  logic [LED_W-1:0]        det_led
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(max3(TRIG_HI, GAP, SETTLE) + 1);

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      ptr_nxt;
  logic [NREQ-1:0]    win;
  logic               win_vld;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   len_raw;
  logic [LEN_W-1:0]   len_clip;
  logic [CW-1:0]      cnt;
  logic [MAX_LEN-1:0] bits;
  logic [LED_W-1:0]   led_fold;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_vld)
  );

  // Encode the one-hot winner for slice select and pointer advance
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NREQ; k++)
      if (win[k]) win_idx = PW'(k);
  end

  assign ptr_nxt  = (win_idx == PW'(NREQ - 1)) ? '0
                  : win_idx + PW'(1);
  assign len_raw  = req_len[int'(win_idx)*LEN_W +: LEN_W];
  assign len_clip = (len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                  : len_raw;

`ifdef PATTERN_DET_ARB_STICKY_EN
  logic [LED_W-1:0] acc;

  // Collect every det_led seen in GAP and SETTLE of this frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (state == ST_CLEAR)
      acc <= '0;
    else if (state == ST_GAP || state == ST_SETTLE)
      acc <= acc | det_led;
  end

  assign led_fold = acc | det_led;
`else
  assign led_fold = det_led;
`endif

  // Frame sequencer; outputs are set for the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      idx      <= '0;
      cnt      <= '0;
      len      <= '0;
      bits     <= '0;
      gnt      <= '0;
      done     <= '0;
      rsp_led  <= '0;
      busy     <= 1'b0;
      det_data <= 1'b0;
      det_trig <= 1'b0;
      det_clr  <= 1'b0;
    end else begin
      done    <= '0;
      det_clr <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state   <= ST_CLEAR;
            gnt     <= win;
            ptr     <= ptr_nxt;
            bits    <= req_data[int'(win_idx)*MAX_LEN +: MAX_LEN];
            len     <= len_clip;
            busy    <= 1'b1;
            det_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          idx <= '0;
          cnt <= '0;
          if (len == '0) begin
            state    <= ST_SETTLE;
            det_data <= 1'b0;
          end else begin
            state    <= ST_DRIVE;
            det_trig <= 1'b1;
            det_data <= bits[0];
          end
        end
        ST_DRIVE: begin
          if (cnt == CW'(TRIG_HI - 1)) begin
            cnt      <= '0;
            state    <= ST_GAP;
            det_trig <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            cnt <= '0;
            if (idx == len - LEN_W'(1)) begin
              state    <= ST_SETTLE;
              det_data <= 1'b0;
            end else begin
              idx      <= idx + LEN_W'(1);
              bits     <= bits >> 1;
              state    <= ST_DRIVE;
              det_trig <= 1'b1;
              det_data <= bits[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          // det_led on the edge entering DONE is the DONE-cycle view
          if (cnt == CW'(SETTLE - 1)) begin
            cnt     <= '0;
            state   <= ST_DONE;
            done    <= gnt;
            rsp_led <= led_fold;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_det_arbiter.sv
// Bench for pattern_det_arbiter: directed cases then random traffic
// against a frame-level timing, arbitration and detector model.
module tb_pattern_det_arbiter;

  localparam int N  = 4;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int TH = 1;
  localparam int GP = 4;
  localparam int ST = 2;
  localparam int P  = TH + GP;
`ifdef PATTERN_DET_ARB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*ML-1:0] req_data;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [4:0]    rsp_led;
  logic          busy;
  logic          det_data;
  logic          det_trig;
  logic          det_clr;
  logic [4:0]    det_led;

  int n_cmp = 0;
  int n_err = 0;

  pattern_det_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .rsp_led  (rsp_led),
    .busy     (busy),
    .det_data (det_data),
    .det_trig (det_trig),
    .det_clr  (det_clr),
    .det_led  (det_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return 0;
  endfunction

  // toy detector: flags over the last three received bits
  function automatic logic [4:0] det_f(input logic [2:0] hh,
                                       input int n);
    logic [4:0] l;
    l    = '0;
    l[0] = (n >= 3) && (hh == 3'b101);
    l[1] = (n >= 3) && (hh == 3'b110);
    l[2] = (n >= 3) && (hh == 3'b011);
    l[3] = (n >= 2) && (hh[1:0] == 2'b11);
    l[4] = (n >= 2) && (hh[1:0] == 2'b00);
    return l;
  endfunction

  // model state
  bit            act, idle_prev, force_mode, rnd_en, trig_q;
  int            mptr, w, fl, off, tcnt, hc;
  logic [ML-1:0] fb;
  logic [N-1:0]  exp_g, req_q;
  logic [4:0]    acc_m, last_m, rsp_m;
  logic [2:0]    h;
  logic [ML-1:0] rd_q [N];
  int            rl_q [N];
  logic [N-1:0]  glog [$];

  // monitor + detector model, away from the active edge
  always @(negedge clk) begin : mon
    logic [4:0] nl;
    int k, ph, dn;
    bit cur;
    if (!reset) begin
      chk("rst_out", {gnt, done, rsp_led, busy,
                      det_data, det_trig, det_clr}, '0);
      act = 0; idle_prev = 0; mptr = 0; rsp_m = '0;
      h = '0; hc = 0; trig_q = 0; det_led = '0;
    end else begin
      if (!act && idle_prev && req_q != '0) begin
        w = rr_pick(req_q, mptr);
        mptr = (w + 1) % N;
        fb = rd_q[w];
        fl = (rl_q[w] > ML) ? ML : rl_q[w];
        exp_g = '0; exp_g[w] = 1'b1;
        act = 1; off = 0; tcnt = 0;
        acc_m = '0; last_m = '0;
      end else if (act) begin
        off++;
      end
      cur = act;
      if (det_clr) glog.push_back(gnt);
      k = (off >= 1) ? (off - 1) / P : 0;
      ph = (off >= 1) ? (off - 1) % P : 0;
      dn = 1 + fl * P + ST;
      if (cur) begin
        chk("gnt", gnt, exp_g);
        chk("busy", busy, 1);
        chk("clr", det_clr, off == 0);
        chk("trig", det_trig, off >= 1 && k < fl && ph < TH);
        if (off >= 1 && k < fl) chk("data", det_data, fb[k]);
        else if (off >= 1) chk("data0", det_data, 0);
        chk("done", done, (off == dn) ? exp_g : '0);
        if (det_trig && !trig_q) tcnt++;
        if (off == dn) begin
          rsp_m = STICKY ? acc_m : last_m;
          chk("rsp", rsp_led, rsp_m);
          chk("ntrig", tcnt, fl);
          act = 0;
        end else begin
          chk("rsp_hold", rsp_led, rsp_m);
        end
      end else begin
        chk("idle", {gnt, done, busy, det_trig, det_clr}, '0);
        chk("rsp_hold", rsp_led, rsp_m);
      end
      idle_prev = !cur;
      trig_q = det_trig;
      if (det_clr) begin h = '0; hc = 0; end
      if (det_trig) begin h = {h[1:0], det_data}; hc++; end
      if (force_mode)
        nl = (cur && off >= 1 + P + TH && off <= 2 * P) ? 5'b00100 : '0;
      else
        nl = det_f(h, hc);
      det_led = nl;
      if (cur && off >= 1 && off < dn) begin
        if ((k < fl && ph >= TH) || k >= fl) acc_m |= nl;
        if (off == dn - 1) last_m = nl;
      end
    end
    req_q = req;
    for (int i = 0; i < N; i++) begin
      rd_q[i] = req_data[i*ML +: ML];
      rl_q[i] = int'(req_len[i*LW +: LW]);
    end
  end

  // random requesters: hold until done, scramble inputs once granted
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (gnt[i]) begin
          req_data[i*ML +: ML] = ML'($urandom);
          req_len[i*LW +: LW]  = LW'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_data[i*ML +: ML] = ML'($urandom);
          req_len[i*LW +: LW]  = ($urandom_range(0, 7) == 0)
                               ? LW'($urandom_range(16, 31))
                               : LW'($urandom_range(0, 6));
          req[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ML-1:0] d,
                         input int l);
    req_data[i*ML +: ML] = d;
    req_len[i*LW +: LW]  = LW'(l);
    req[i] = 1'b1;
  endtask

  task automatic wait_done(input int i, output int n);
    bit hit;
    hit = 0;
    n = 0;
    while (!hit && n < 400) begin
      step();
      n++;
      if (done[i]) begin
        hit = 1;
        req[i] = 1'b0;
      end
    end
    chk("done_seen", hit, 1);
  endtask

  initial begin
    int n;
    bit hit;
    req = '0; req_data = '0; req_len = '0;
    rnd_en = 0; force_mode = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) step();

    // single frame 101, release reset with req0 already up
    set_req(0, 16'b101, 3);
    reset = 1'b1;
    wait_done(0, n);
    chk("t1_cyc", n, 19);
    chk("t1_rsp", rsp_led, 5'b00001);
    step();

    // arbitration order 0,2 then 0,1
    reset = 1'b0;
    step();
    glog.delete();
    set_req(0, ML'($urandom), 2);
    set_req(2, ML'($urandom), 1);
    reset = 1'b1;
    wait_done(0, n);
    hit = 0;
    n = 0;
    while (!hit && n < 50) begin
      step();
      n++;
      hit = gnt[2];
    end
    chk("gnt2_seen", hit, 1);
    set_req(0, ML'($urandom), 1);
    set_req(1, ML'($urandom), 2);
    wait_done(2, n);
    wait_done(0, n);
    wait_done(1, n);
    chk("t2_n", glog.size(), 4);
    if (glog.size() >= 4)
      chk("t2_order", {glog[0], glog[1], glog[2], glog[3]}, 16'h1412);
    step();

    // zero length
    set_req(0, ML'($urandom), 0);
    wait_done(0, n);
    chk("t3_cyc", n, 4);
    step();

    // over-long length clamps to MAX_LEN bits
    set_req(3, ML'($urandom), 20);
    wait_done(3, n);
    chk("t4_cyc", n, 84);
    step();

    // async reset during bit 1
    set_req(0, 16'hffff, 5);
    repeat (7) step();
    chk("t5_trig", det_trig, 1);
    reset = 1'b0;
    #1;
    chk("t5_async", {gnt, done, busy, det_trig,
                     det_clr, det_data, rsp_led}, '0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("t5_clr", det_clr, 1);
    wait_done(0, n);
    step();

    // led only during bit 1 gap
    force_mode = 1;
    set_req(1, 16'b011, 3);
    wait_done(1, n);
    chk("t6_rsp", rsp_led, STICKY ? 5'b00100 : 5'b00000);
    step();
    force_mode = 0;

    // random traffic
    rnd_en = 1;
    repeat (3000) @(posedge clk);
    #1;
    rnd_en = 0;
    n = 0;
    while ((req != '0 || busy) && n < 3000) begin
      step();
      n++;
      for (int i = 0; i < N; i++)
        if (done[i]) req[i] = 1'b0;
    end
    chk("drain", (req == '0) && !busy, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
